// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin sharing of one Avalon-MM master port between fetch (I) and data (D) requesters.
// Define MIPS_BUS_ARB_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES waitrequest-high cycles.
module mips_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_done,
   output logic [31:0] rdata,
   output logic        bus_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_nxt;
   logic last_d;
   logic grant_d;
   logic start;
   logic ack;
   logic abort;
   // last_d doubles as the owner of the transfer in flight
   assign grant_d = d_req & (~i_req | ~last_d);
   assign start = state == IDLE && (i_req || d_req);
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   assign abort = state == ACCESS && waitrequest && cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= '0;
      else if (state == IDLE) cnt <= '0;
      else if (state == ACCESS && waitrequest) cnt <= cnt + 1'b1;
   end
`else
   assign abort = 1'b0;
`endif
   assign ack = state == ACCESS && (!waitrequest || abort);
   always_comb begin
      state_nxt = state;
      if (start) state_nxt = ACCESS;
      else if (ack) state_nxt = DONE;
      else if (state == DONE) state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_d     <= 1'b0;
         address    <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
         byteenable <= 4'b0000;
         rdata      <= '0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         bus_err <= 1'b0;
         if (start) begin
            last_d     <= grant_d;
            address    <= grant_d ? d_addr : i_addr;
            read       <= ~grant_d | ~d_we;
            write      <= grant_d & d_we;
            writedata  <= grant_d ? d_wdata : '0;
            byteenable <= grant_d ? d_be : 4'b1111;
         end else if (ack) begin
            read    <= 1'b0;
            write   <= 1'b0;
            i_done  <= ~last_d;
            d_done  <= last_d;
            bus_err <= abort;
            if (read) rdata <= abort ? '1 : readdata;
         end
      end
   end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed transfers against a stalling Avalon slave model, scoreboard-checked on done pulses.
module tb_mips_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        d_done;
   logic [31:0] rdata;
   logic        bus_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = '0;

   mips_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_done(d_done),
      .rdata(rdata), .bus_err(bus_err),
      .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t q[$];

   int vectors = 0;
   int miscompares = 0;
   int stall = 0;
   int wcnt = 0;
   logic [31:0] rd_val = '0;
   logic [31:0] exp_rdata = '0;
   logic [69:0] snap;
   logic [31:0] log_addr = '0;
   logic        log_we = 1'b0;
   logic [31:0] log_wdata = '0;
   logic [3:0]  log_be = '0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic push_exp(input logic is_d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic err);
      exp_t e;
      e.is_d = is_d; e.we = we; e.addr = a; e.wdata = wd; e.be = be; e.err = err;
      if (!we) exp_rdata = err ? 32'hFFFF_FFFF : rd_val;
      e.rdata = exp_rdata;
      q.push_back(e);
   endtask

   // Avalon slave: stalls each transfer for `stall` cycles and checks the bus stays frozen meanwhile
   always @(negedge clk) begin
      if (!reset) begin
         waitrequest = 1'b0;
         wcnt = 0;
      end else if (read || write) begin
         if (wcnt == 0) snap = {address, read, write, writedata, byteenable};
         else check("frozen", 64'({address, read, write, writedata, byteenable} != snap), 64'd0);
         if (read && write) check("rw_exclusive", 64'd1, 64'd0);
         if (wcnt < stall) begin
            waitrequest = 1'b1;
            wcnt++;
         end else begin
            waitrequest = 1'b0;
            readdata = rd_val;
            log_addr = address; log_we = write; log_wdata = writedata; log_be = byteenable;
         end
      end else begin
         waitrequest = 1'b0;
         wcnt = 0;
      end
   end

   always @(negedge clk) begin
      if (reset && (i_done || d_done)) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done i_done=%b d_done=%b", i_done, d_done);
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({i_done, d_done, rdata, bus_err} !== {~e.is_d, e.is_d, e.rdata, e.err}) begin
               miscompares++;
               $display("FAIL done_resp got i/d=%b%b rdata=%h err=%b exp i/d=%b%b rdata=%h err=%b",
                        i_done, d_done, rdata, bus_err, ~e.is_d, e.is_d, e.rdata, e.err);
            end else if (!e.err && {log_addr, log_we, log_wdata, log_be} !== {e.addr, e.we, e.wdata, e.be}) begin
               miscompares++;
               $display("FAIL bus_xfer got addr=%h we=%b wd=%h be=%h exp addr=%h we=%b wd=%h be=%h",
                        log_addr, log_we, log_wdata, log_be, e.addr, e.we, e.wdata, e.be);
            end
         end
      end
   end

   task automatic xfer(input logic is_d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int st, input int exp_n, input logic err);
      int w = 0;
      int n = 0;
      stall = st;
      push_exp(is_d, we, a, wd, be, err);
      @(negedge clk);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
      end else begin
         i_req = 1'b1; i_addr = a;
      end
      @(negedge clk);
      while (!(read || write) && w < 50) begin w++; @(negedge clk); end
      while ((read || write) && n < 2000) begin n++; @(negedge clk); end
      check("latency", 64'(w), 64'd0);
      check("strobe_cycles", 64'(n), 64'(exp_n));
      check("done_timing", 64'(is_d ? d_done : i_done), 64'd1);
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      #12;
      check("reset_state", 64'({address, read, write, writedata, byteenable, rdata, i_done, d_done, bus_err}), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      // both requesting out of reset: D first, then strict alternation
      stall = 0;
      rd_val = 32'h1111_2222;
      repeat (2) begin
         push_exp(1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D, 4'hF, 1'b0);
         push_exp(1'b0, 1'b0, 32'h0400, 32'h0, 4'hF, 1'b0);
      end
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h0400;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; d_be = 4'hF;
      k = 0;
      for (int c = 0; c < 60 && k < 4; c++) begin
         @(negedge clk);
         if (i_done || d_done) k++;
      end
      check("tie_done_count", 64'(k), 64'd4);
      i_req = 1'b0;
      d_req = 1'b0;
      rd_val = 32'h2402_0005;
      xfer(1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 0, 1, 1'b0);
      xfer(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3, 4, 1'b0);
      rd_val = 32'h7654_3210;
      xfer(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'b1100, 1, 2, 1'b0);
      // requester changes its mind mid-transfer; the granted request still completes
      stall = 2;
      rd_val = 32'h55AA_33CC;
      push_exp(1'b1, 1'b0, 32'h3000, 32'h0, 4'b0101, 1'b0);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h0; d_be = 4'b0101;
      @(negedge clk);
      d_req = 1'b0; d_addr = 32'h9999; d_we = 1'b1;
      k = 0;
      for (int c = 0; c < 20 && k == 0; c++) begin
         @(negedge clk);
         if (d_done) k = 1;
      end
      check("mid_change_done", 64'(k), 64'd1);
      repeat (3) @(negedge clk);
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
      xfer(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 1000, 4, 1'b1);
      stall = 0;
      repeat (2) @(negedge clk);
`endif
      // asynchronous reset while a read is stalled
      stall = 100;
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h0000_0500;
      k = 0;
      for (int c = 0; c < 20 && !read; c++) @(negedge clk);
      check("stall_read_up", 64'(read), 64'd1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1 check("async_reset", 64'({read, write, i_done, d_done, address}), 64'd0);
      i_req = 1'b0;
      exp_rdata = '0;
      @(negedge clk);
      reset = 1'b1;
      stall = 0;
      repeat (3) begin
         @(negedge clk);
         check("no_stale_done", 64'({i_done, d_done, read, write}), 64'd0);
      end
      rd_val = 32'h0BAD_F00D;
      xfer(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, 2, 1'b0);
      repeat (5) @(negedge clk);
      check("queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
